// File: rtl/shift_reg_sipo_if.sv
// Serial-link and word-handshake bundle between a bit source, shift_reg_sipo and the word consumer.
interface shift_reg_sipo_if #(
   parameter int size = 8
);
   logic            datain;
   logic            din_valid;
   logic            din_sof;
   logic [size-1:0] dataout;
   logic            dout_valid;
   logic            dout_ready;
   logic            overrun;
   logic            frame_err;

   modport master (
      output datain, din_valid, din_sof, dout_ready,
      input  dataout, dout_valid, overrun, frame_err
   );

   modport slave (
      input  datain, din_valid, din_sof, dout_ready,
      output dataout, dout_valid, overrun, frame_err
   );
endinterface

// File: rtl/shift_reg_sipo.sv
// Serial-in parallel-out collector: aligns words on a start-of-frame marker and
// presents each completed word through a one-entry valid/ready holding register.
module shift_reg_sipo #(
   parameter int size      = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit SOF_ALIGN = 1'b1
) (
   input logic             clk,
   input logic             reset,
   shift_reg_sipo_if.slave bus
);
   localparam int CW = $clog2(size + 1);

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [size-1:0] acc_q, acc_d;
   logic [size-1:0] dataout_q, dataout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;
   logic            take_bit;
   logic            complete;
   logic            consume;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      dataout_d    = dataout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
      frame_err_d  = 1'b0;
      complete     = 1'b0;
      consume      = dout_valid_q && bus.dout_ready;
      take_bit     = bus.din_valid && ((state_q == COLLECT) || bus.din_sof);

      if (take_bit) begin
         state_d = COLLECT;
         if (MSB_FIRST) acc_d = {acc_q[size-2:0], bus.datain};
         else           acc_d = {bus.datain, acc_q[size-1:1]};

         // A marker always restarts the word; older bits simply shift out before completion.
         if (bus.din_sof) begin
            frame_err_d = (state_q == COLLECT) && (cnt_q != '0);
            cnt_d       = CW'(1);
         end else if (cnt_q == CW'(size - 1)) begin
            cnt_d    = '0;
            complete = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (complete) begin
         if (!dout_valid_q || bus.dout_ready) begin
            dataout_d    = acc_d;
            dout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (consume) begin
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SOF_ALIGN ? HUNT : COLLECT;
         cnt_q        <= '0;
         acc_q        <= '0;
         dataout_q    <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         dataout_q    <= dataout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.dataout    = dataout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.overrun    = overrun_q;
   assign bus.frame_err  = frame_err_q;
endmodule
